// File: rtl/control_pkg.sv
// Shared definitions for the multicycle controller: state encoding (the
// numeric values are visible on StateOut), opcode constants and the codes
// driven onto the ALUOp, PCSource and ALUSrcB buses.
package control_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_IMMEX    = 4'd10,
        S_IMMWB    = 4'd11,
        S_EXCEPT   = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // States in which the controller waits on the memory handshake.
    function automatic logic is_mem_wait(input state_e s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles spent waiting on memory.
//   clk     : rising-edge clock
//   clear   : zero the count (state entry or reset)
//   inc     : one more waiting cycle this cycle (saturating)
//   expired : this waiting cycle is the TIMEOUT_CYCLES-th in a row;
//             never asserted when TIMEOUT_CYCLES is 0
module mem_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    // cnt_q holds the low cycles already seen, so the current low cycle is
    // number cnt_q+1; expiry is flagged while that cycle is still running so
    // the controller can move to EXCEPT on the following edge.
    assign expired = (TIMEOUT_CYCLES != 0) && inc && (cnt_q == CNT_LAST);

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle datapath.
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   Op                  : opcode field of the instruction register
//   MemReady            : memory completes the current access this cycle
//   PCWriteCond .. RegDst, PCSource, ALUSrcB, ALUOp, BranchNE : datapath controls
//   Exception           : sticky illegal-opcode / memory-timeout flag
//   StateOut            : current state index, zero-extended to STATE_W
// STATE_W must be at least 4.
module multicycle_control
    import control_pkg::*;
#(
    parameter int unsigned STATE_W        = 8,
    parameter int unsigned MEM_HANDSHAKE  = 1,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Op,
    input  logic               MemReady,
    output logic               PCWriteCond,
    output logic               PCWrite,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               IRWrite,
    output logic               ALUSrcA,
    output logic               RegWrite,
    output logic               RegDst,
    output logic [1:0]         PCSource,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUOp,
    output logic               BranchNE,
    output logic               Exception,
    output logic [STATE_W-1:0] StateOut
);

    state_e state_q;
    state_e state_d;
    state_e out_sel;
    logic   mem_rdy;
    logic   tmr_clear;
    logic   tmr_inc;
    logic   tmr_expired;

    assign mem_rdy = (MEM_HANDSHAKE != 0) ? MemReady : 1'b1;

    // Clearing on every state change gives a zero count on entry to each wait
    // state, including MEMWRITE -> FETCH where both ends are wait states.
    assign tmr_clear = reset || (state_d != state_q);
    assign tmr_inc   = is_mem_wait(state_q) && !mem_rdy;

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk    (clk),
        .clear  (tmr_clear),
        .inc    (tmr_inc),
        .expired(tmr_expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_rdy)          state_d = S_DECODE;
                else if (tmr_expired) state_d = S_EXCEPT;
            end
            S_DECODE: begin
                case (Op)
                    OP_RTYPE:                  state_d = S_EXECUTE;
                    OP_LW, OP_SW:              state_d = S_MEMADR;
                    OP_BEQ, OP_BNE:            state_d = S_BRANCH;
                    OP_J:                      state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_IMMEX;
                    default:                   state_d = S_EXCEPT;
                endcase
            end
            S_MEMADR:   state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: begin
                if (mem_rdy)          state_d = S_MEMWB;
                else if (tmr_expired) state_d = S_EXCEPT;
            end
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: begin
                if (mem_rdy)          state_d = S_FETCH;
                else if (tmr_expired) state_d = S_EXCEPT;
            end
            S_EXECUTE:  state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_IMMEX:    state_d = S_IMMWB;
            S_IMMWB:    state_d = S_FETCH;
            S_EXCEPT:   state_d = S_EXCEPT;
            default:    state_d = S_EXCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // While reset is held the FETCH decode is shown regardless of the
    // registered state, with the Mealy IR/PC strobes suppressed.
    always_comb begin
        PCWriteCond = 1'b0;
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = PC_ALU;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALU_ADD;
        BranchNE    = 1'b0;
        Exception   = 1'b0;
        out_sel     = reset ? S_FETCH : state_q;
        case (out_sel)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_rdy && !reset;
                PCWrite = mem_rdy && !reset;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMMSH;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PC_ALUOUT;
                BranchNE    = (Op == OP_BNE);
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PC_JUMP;
            end
            S_IMMEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                case (Op)
                    OP_ANDI: ALUOp = ALU_AND;
                    OP_ORI:  ALUOp = ALU_OR;
                    default: ALUOp = ALU_ADD;
                endcase
            end
            S_IMMWB: begin
                RegWrite = 1'b1;
            end
            S_EXCEPT: begin
                Exception = 1'b1;
            end
            default: ;
        endcase
    end

    assign StateOut = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic       MemReady;
    logic       PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst, BranchNE, Exception;
    logic [1:0] PCSource, ALUSrcB;
    logic [2:0] ALUOp;
    logic [7:0] StateOut;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic       pcwc, pcw, iord, mr, mw, mtr, irw, srca, rw, rdst;
        logic [1:0] pcsrc, srcb;
        logic [2:0] aluop;
        logic       bne, exc;
    } outs_t;

    typedef struct {
        int   st;
        logic rdy;
    } step_t;

    outs_t obs;
    step_t plan[$];

    assign obs = {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                  ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, BranchNE, Exception};

    multicycle_control #(
        .STATE_W(8),
        .MEM_HANDSHAKE(1),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .Op(Op), .MemReady(MemReady),
        .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
        .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .BranchNE(BranchNE), .Exception(Exception), .StateOut(StateOut)
    );

    always #5 clk = ~clk;

    // Expected controls for a state index, straight from the state table.
    function automatic outs_t exp_outs(input int st, input logic [5:0] op, input logic rdy);
        outs_t o;
        o = '0;
        case (st)
            0:  begin o.mr = 1; o.srcb = 2'b01; o.irw = rdy; o.pcw = rdy; end
            1:  o.srcb = 2'b11;
            2:  begin o.srca = 1; o.srcb = 2'b10; end
            3:  begin o.mr = 1; o.iord = 1; end
            4:  begin o.mtr = 1; o.rw = 1; end
            5:  begin o.mw = 1; o.iord = 1; end
            6:  begin o.srca = 1; o.aluop = 3'b010; end
            7:  begin o.rdst = 1; o.rw = 1; end
            8:  begin o.srca = 1; o.aluop = 3'b001; o.pcwc = 1; o.pcsrc = 2'b01; o.bne = (op == 6'b000101); end
            9:  begin o.pcw = 1; o.pcsrc = 2'b10; end
            10: begin
                o.srca = 1; o.srcb = 2'b10;
                o.aluop = (op == 6'b001100) ? 3'b011 : (op == 6'b001101) ? 3'b100 : 3'b000;
            end
            11: o.rw = 1;
            12: o.exc = 1;
            default: ;
        endcase
        return o;
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                          6'b000010, 6'b001000, 6'b001100, 6'b001101};
    endfunction

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        MemReady = 1'b0;
        go();
        reset = 1'b0;
    endtask

    // A memory state that sees `lat` low cycles before completing; TO or more
    // low cycles ends in EXCEPT instead.
    task automatic plan_mem(input int st, input int lat, output bit timed_out);
        timed_out = (lat >= TO);
        for (int i = 0; i < ((lat >= TO) ? TO : lat); i++) plan.push_back('{st, 1'b0});
        if (!timed_out) plan.push_back('{st, 1'b1});
    endtask

    task automatic test_reset();
        outs_t e;
        reset = 1'b1; MemReady = 1'b1; Op = 6'b000000;
        settle();
        e = exp_outs(0, Op, 1'b0);
        n_cmp++; if (obs !== e) begin n_err++; $display("FAIL reset_outs_pre: got %h expected %h", obs, e); end
        go();
        MemReady = 1'b0;
        settle();
        n_cmp++; if (StateOut !== 8'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", StateOut); end
        n_cmp++; if (obs !== e) begin n_err++; $display("FAIL reset_outs_held: got %h expected %h", obs, e); end
        go();
        reset = 1'b0; MemReady = 1'b1;
        settle();
        e = exp_outs(0, Op, 1'b1);
        n_cmp++; if (obs !== e) begin n_err++; $display("FAIL reset_release_fetch: got %h expected %h", obs, e); end
        go();
        settle();
        n_cmp++; if (StateOut !== 8'd1) begin n_err++; $display("FAIL reset_to_decode: got %0d expected 1", StateOut); end
    endtask

    task automatic test_rtype();
        int exp_st[5] = '{0, 1, 6, 7, 0};
        do_reset();
        Op = 6'b000000; MemReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            n_cmp++; if (StateOut !== 8'(exp_st[i])) begin n_err++; $display("FAIL rtype_state step %0d: got %0d expected %0d", i, StateOut, exp_st[i]); end
            n_cmp++; if ({RegWrite, RegDst} !== {2{exp_st[i] == 7}}) begin n_err++; $display("FAIL rtype_regwrite step %0d: got %b expected %b", i, {RegWrite, RegDst}, {2{exp_st[i] == 7}}); end
            go();
        end
    endtask

    task automatic test_lw_wait();
        int   exp_st[9]  = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
        logic rdy_seq[9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
        outs_t e;
        do_reset();
        Op = 6'b100011;
        for (int i = 0; i < 9; i++) begin
            MemReady = rdy_seq[i];
            settle();
            e = exp_outs(exp_st[i], Op, rdy_seq[i]);
            n_cmp++; if (StateOut !== 8'(exp_st[i])) begin n_err++; $display("FAIL lw_state step %0d: got %0d expected %0d", i, StateOut, exp_st[i]); end
            n_cmp++; if (obs !== e) begin n_err++; $display("FAIL lw_outs step %0d: got %h expected %h", i, obs, e); end
            if (i == 7) begin
                n_cmp++; if (MemtoReg !== 1'b1) begin n_err++; $display("FAIL lw_memtoreg: got %b expected 1", MemtoReg); end
            end
            go();
        end
    endtask

    task automatic test_branch();
        int exp_st[4] = '{0, 1, 8, 0};
        for (int k = 0; k < 2; k++) begin
            do_reset();
            Op = (k == 0) ? 6'b000101 : 6'b000100;
            MemReady = 1'b1;
            for (int i = 0; i < 4; i++) begin
                settle();
                n_cmp++; if (StateOut !== 8'(exp_st[i])) begin n_err++; $display("FAIL branch_state op %b step %0d: got %0d expected %0d", Op, i, StateOut, exp_st[i]); end
                if (exp_st[i] == 8) begin
                    n_cmp++;
                    if ({PCWriteCond, BranchNE, ALUOp} !== {1'b1, (k == 0), 3'b001}) begin
                        n_err++; $display("FAIL branch_ctrl op %b: got pcwc=%b bne=%b aluop=%b expected 1 %b 001", Op, PCWriteCond, BranchNE, ALUOp, (k == 0));
                    end
                end
                go();
            end
        end
    endtask

    task automatic test_illegal();
        outs_t e;
        do_reset();
        Op = 6'b111111; MemReady = 1'b1;
        go(); go();
        for (int i = 0; i < 5; i++) begin
            MemReady = 1'($urandom_range(0, 1));
            settle();
            n_cmp++; if (StateOut !== 8'd12 || Exception !== 1'b1) begin n_err++; $display("FAIL illegal_held cycle %0d: got state %0d exc %b expected 12 1", i, StateOut, Exception); end
            go();
        end
        reset = 1'b1; MemReady = 1'b0;
        settle();
        e = exp_outs(0, Op, 1'b0);
        n_cmp++; if (obs !== e) begin n_err++; $display("FAIL illegal_reset_outs: got %h expected %h", obs, e); end
        go();
        reset = 1'b0;
        settle();
        n_cmp++; if (StateOut !== 8'd0 || Exception !== 1'b0) begin n_err++; $display("FAIL illegal_cleared: got state %0d exc %b expected 0 0", StateOut, Exception); end
    endtask

    task automatic test_timeout();
        for (int p = 0; p < 2; p++) begin
            int n;
            bit left;
            do_reset();
            Op = 6'b101011; MemReady = 1'b1;
            go(); go(); go();
            n = 0; left = 0;
            for (int c = 0; c < 40; c++) begin
                MemReady = (p == 1 && n == TO - 1);
                settle();
                if (StateOut != 8'd5) begin left = 1; break; end
                n++;
                go();
            end
            n_cmp++;
            if (!left) begin
                n_err++; $display("FAIL timeout_bound pass %0d: still in MEMWRITE after 40 cycles", p);
            end else if (n != TO || StateOut !== ((p == 0) ? 8'd12 : 8'd0)) begin
                n_err++; $display("FAIL timeout_exit pass %0d: got %0d cycles then state %0d expected %0d then %0d", p, n, StateOut, TO, (p == 0) ? 12 : 0);
            end
            if (p == 0) begin
                n_cmp++; if (Exception !== 1'b1) begin n_err++; $display("FAIL timeout_exception: got %b expected 1", Exception); end
            end
        end
    endtask

    task automatic test_reset_midwait();
        do_reset();
        Op = 6'b100011; MemReady = 1'b1;
        go(); go(); go();
        MemReady = 1'b0;
        for (int i = 0; i < 5; i++) go();
        reset = 1'b1;
        go();
        reset = 1'b0;
        // Fourteen low cycles then ready: only fits if the reset cleared the count.
        for (int i = 0; i < TO; i++) begin
            MemReady = (i == TO - 1);
            settle();
            if (i == 0) begin
                n_cmp++;
                if ({MemRead, IorD, IRWrite} !== 3'b100) begin
                    n_err++; $display("FAIL midwait_fetch_outs: got mr=%b iord=%b irw=%b expected 1 0 0", MemRead, IorD, IRWrite);
                end
            end
            n_cmp++; if (StateOut !== 8'd0) begin n_err++; $display("FAIL midwait_fetch_state cycle %0d: got %0d expected 0", i, StateOut); end
            go();
        end
        settle();
        n_cmp++; if (StateOut !== 8'd1) begin n_err++; $display("FAIL midwait_timer_cleared: got %0d expected 1", StateOut); end
    endtask

    task automatic test_random();
        logic [5:0] legal_ops[9] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                     6'b000010, 6'b001000, 6'b001100, 6'b001101};
        do_reset();
        for (int n = 0; n < 40; n++) begin
            logic [5:0] op;
            bit         to;
            int         r;
            outs_t      e;
            r = $urandom_range(0, 10);
            if (r < 9) op = legal_ops[r];
            else begin
                op = 6'b111111;
                for (int t = 0; t < 20; t++) begin
                    op = 6'($urandom_range(0, 63));
                    if (!is_legal(op)) break;
                end
                if (is_legal(op)) op = 6'b111111;
            end
            plan.delete();
            plan_mem(0, pick_lat(), to);
            if (!to) begin
                plan.push_back('{1, 1'($urandom_range(0, 1))});
                case (op)
                    6'b000000: begin plan.push_back('{6, 1'b1}); plan.push_back('{7, 1'b0}); end
                    6'b100011: begin plan.push_back('{2, 1'b0}); plan_mem(3, pick_lat(), to); if (!to) plan.push_back('{4, 1'b0}); end
                    6'b101011: begin plan.push_back('{2, 1'b1}); plan_mem(5, pick_lat(), to); end
                    6'b000100, 6'b000101: plan.push_back('{8, 1'($urandom_range(0, 1))});
                    6'b000010: plan.push_back('{9, 1'($urandom_range(0, 1))});
                    6'b001000, 6'b001100, 6'b001101: begin plan.push_back('{10, 1'b0}); plan.push_back('{11, 1'b1}); end
                    default: to = 1;
                endcase
            end
            if (to) for (int i = 0; i < 3; i++) plan.push_back('{12, 1'($urandom_range(0, 1))});
            Op = op;
            foreach (plan[i]) begin
                MemReady = plan[i].rdy;
                settle();
                e = exp_outs(plan[i].st, op, plan[i].rdy);
                n_cmp++; if (StateOut !== 8'(plan[i].st)) begin n_err++; $display("FAIL rnd_state instr %0d op %b step %0d: got %0d expected %0d", n, op, i, StateOut, plan[i].st); end
                n_cmp++; if (obs !== e) begin n_err++; $display("FAIL rnd_outs instr %0d op %b step %0d: got %h expected %h", n, op, i, obs, e); end
                go();
            end
            if (to) begin
                reset = 1'b1;
                MemReady = 1'($urandom_range(0, 1));
                settle();
                e = exp_outs(0, op, 1'b0);
                n_cmp++; if (obs !== e) begin n_err++; $display("FAIL rnd_reset_outs instr %0d: got %h expected %h", n, obs, e); end
                go();
                reset = 1'b0;
            end
        end
    endtask

    function automatic int pick_lat();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return TO;
        if (r == 1) return TO - 1;
        if (r <= 4) return $urandom_range(4, 8);
        return $urandom_range(0, 2);
    endfunction

    initial begin
        reset = 1'b1;
        MemReady = 1'b0;
        Op = 6'b000000;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_branch();
        test_illegal();
        test_timeout();
        test_reset_midwait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
